// File: rtl/lc_pkg.sv
// rtl/lc_pkg.sv - shared lifecycle types for the transition requester and responder
package lc_pkg;

    localparam int LC_WIDTH = 3;
    localparam int LC_EOL   = 5;

    typedef enum logic [1:0] {
        LC_OK        = 2'd0,
        LC_DENIED    = 2'd1,
        LC_REJECTED  = 2'd2,
        LC_STATE_ERR = 2'd3
    } lc_status_t;

    typedef enum logic [2:0] {
        REQ_IDLE    = 3'd0,
        REQ_REQ     = 3'd1,
        REQ_RELEASE = 3'd2,
        REQ_GUARD   = 3'd3,
        REQ_RESP    = 3'd4
    } req_state_t;

endpackage

// File: rtl/lc_req_timer.sv
// rtl/lc_req_timer.sv - loadable up-counter with terminal-count flag
module lc_req_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] term_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/lc_transition_requester.sv
// rtl/lc_transition_requester.sv - lifecycle transition handshake initiator
module lc_transition_requester #(
    parameter int ID_WIDTH     = 256,
    parameter int LC_WIDTH     = 3,
    parameter int TIMEOUT      = 16,
    parameter int GUARD_CYCLES = 2,
    parameter int MAX_FAILS    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [LC_WIDTH-1:0] cmd_target_lc,
    input  logic [ID_WIDTH-1:0] cmd_identifier,
    output logic                transition_request,
    output logic [ID_WIDTH-1:0] identifier,
    input  logic                success,
    input  logic [LC_WIDTH-1:0] lc_state,
    output logic                rsp_valid,
    output logic [1:0]          rsp_status,
    output logic [LC_WIDTH-1:0] rsp_lc,
    output logic                locked
);
    import lc_pkg::*;

    localparam int TMAX = (TIMEOUT > GUARD_CYCLES) ? TIMEOUT : GUARD_CYCLES;
    localparam int TW   = $clog2(TMAX);
    localparam int FW   = $clog2(MAX_FAILS + 1);

    req_state_t          state_q, state_d;
    lc_status_t          status_q, status_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [LC_WIDTH-1:0] tgt_q, tgt_d;
    logic [FW-1:0]       fail_q, fail_d, fail_inc;
    logic                locked_q, locked_d;
    logic                tmr_clr, tmr_en, tmr_tc;
    logic [TW-1:0]       tmr_term;
    logic                precheck_fail;

    // Target must be exactly one step ahead; below EOL the increment cannot wrap.
    assign precheck_fail = locked_q
                        || (lc_state >= LC_WIDTH'(LC_EOL))
                        || (cmd_target_lc != lc_state + LC_WIDTH'(1));

    assign fail_inc = (fail_q == FW'(MAX_FAILS)) ? fail_q : fail_q + 1'b1;

    lc_req_timer #(.WIDTH(TW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (tmr_clr),
        .en_i   (tmr_en),
        .term_i (tmr_term),
        .tc_o   (tmr_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= REQ_IDLE;
            status_q <= LC_OK;
            id_q     <= '0;
            tgt_q    <= '0;
            fail_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            id_q     <= id_d;
            tgt_q    <= tgt_d;
            fail_q   <= fail_d;
            locked_q <= locked_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        id_d     = id_q;
        tgt_d    = tgt_q;
        fail_d   = fail_q;
        locked_d = locked_q;
        tmr_clr  = 1'b0;
        tmr_en   = 1'b0;
        tmr_term = TW'(TIMEOUT - 1);
        case (state_q)
            REQ_IDLE: begin
                if (cmd_valid) begin
                    if (precheck_fail) begin
                        status_d = LC_REJECTED;
                        state_d  = REQ_RESP;
                    end else begin
                        id_d    = cmd_identifier;
                        tgt_d   = cmd_target_lc;
                        tmr_clr = 1'b1;
                        state_d = REQ_REQ;
                    end
                end
            end
            REQ_REQ: begin
                // A grant arriving on the expiry cycle takes precedence over the timeout.
                if (success) begin
                    status_d = (lc_state == tgt_q) ? LC_OK : LC_STATE_ERR;
                    if (lc_state == tgt_q) begin
                        fail_d = '0;
                    end
                    id_d    = '0;
                    state_d = REQ_RELEASE;
                end else if (tmr_tc) begin
                    status_d = LC_DENIED;
                    fail_d   = fail_inc;
                    if (fail_inc == FW'(MAX_FAILS)) begin
                        locked_d = 1'b1;
                    end
                    id_d    = '0;
                    state_d = REQ_RELEASE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            REQ_RELEASE: begin
                if (!success) begin
                    tmr_clr = 1'b1;
                    state_d = REQ_GUARD;
                end
            end
            REQ_GUARD: begin
                tmr_term = TW'(GUARD_CYCLES - 1);
                if (tmr_tc) begin
                    state_d = REQ_RESP;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            REQ_RESP: begin
                state_d = REQ_IDLE;
            end
            default: begin
                state_d = REQ_IDLE;
            end
        endcase
    end

    assign cmd_ready          = rst && (state_q == REQ_IDLE);
    assign transition_request = (state_q == REQ_REQ);
    assign identifier         = id_q;
    assign rsp_valid          = (state_q == REQ_RESP);
    assign rsp_status         = rsp_valid ? status_q : LC_OK;
    assign rsp_lc             = rsp_valid ? lc_state : '0;
    assign locked             = locked_q;

endmodule

// File: doc/lc_transition_requester.md
# lc_transition_requester

Host-side initiator for the lifecycle transition handshake. Accepts single-step lifecycle advance commands and pre-checks them against the current lifecycle state. It drives the `transition_request`/`identifier` handshake into the lifecycle protection block, then classifies the outcome as OK, denied, rejected or state error, and reports it as a one-cycle response. Sits between the SoC security controller (command side) and the lifecycle protection block (responder side).

## Interface
Parameters:
- `ID_WIDTH`, 256: identifier width.
- `LC_WIDTH`, 3: lifecycle state width.
- `TIMEOUT`, 16: maximum cycles `transition_request` is held waiting for `success`; must be ≥2.
- `GUARD_CYCLES`, 2: idle cycles with request low before the response; must be ≥1.
- `MAX_FAILS`, 3: consecutive DENIED outcomes before lock.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_target_lc` in LC_WIDTH: requested next lifecycle state.
- `cmd_identifier` in ID_WIDTH: owner signature for the current state.
- `transition_request` out 1: request to the responder.
- `identifier` out ID_WIDTH: signature presented to the responder.
- `success` in 1: responder grant.
- `lc_state` in LC_WIDTH: responder's current lifecycle state.
- `rsp_valid` out 1: one-cycle response strobe.
- `rsp_status` out 2: 0 OK, 1 DENIED, 2 REJECTED, 3 STATE_ERR.
- `rsp_lc` out LC_WIDTH: `lc_state` sampled at response.
- `locked` out 1: sticky lockout.

## Operation
- Reset values: `cmd_ready` 0 during reset, 1 in IDLE after reset. All other outputs are 0, including `identifier` and the fail counter. FSM state is IDLE.
- FSM states: IDLE, REQ, RELEASE, GUARD, RESP.
- **IDLE**
  - `cmd_ready`=1. Acceptance occurs when `cmd_valid && cmd_ready`.
  - Pre-check at acceptance: reject if `locked`, or `lc_state >= LC_EOL` (5), or `cmd_target_lc != lc_state+1` (LC_WIDTH arithmetic, no wrap allowed).
  - Reject: status REJECTED, go to RESP, no request issued.
  - Pass: capture the identifier, clear the timer, go to REQ.
- **REQ**
  - `transition_request`=1 and `identifier` = captured value.
  - If `success`=1: status OK if `lc_state == cmd_target_lc`, else STATE_ERR. Go to RELEASE.
  - Else if timer == TIMEOUT-1: status DENIED, go to RELEASE.
  - Else timer +1.
- **RELEASE**
  - `transition_request`=0 and the identifier register is zeroed; secrets are never held after REQ.
  - Wait for `success`=0, then go to GUARD.
- **GUARD**: count GUARD_CYCLES cycles with request low, then go to RESP.
- **RESP**
  - `rsp_valid`=1 for exactly one cycle, with `rsp_status` and `rsp_lc`=`lc_state`.
  - Then go to IDLE. No backpressure on the response.
- Fail counter:
  - DENIED increments it, saturating at MAX_FAILS.
  - OK clears it. REJECTED and STATE_ERR leave it unchanged.
  - Reaching MAX_FAILS sets `locked`. `locked` is cleared only by reset.
- `success` is ignored outside REQ and RELEASE.

## Timing
- Accept edge N → `transition_request` high from N+1.
- `success` seen high in cycle M → request low from M+1.
- Response latency for a granted request: M + (cycles until `success` low) + GUARD_CYCLES + 1.
- Denied request: request is high for exactly TIMEOUT cycles.
- Rejected command: `rsp_valid` in cycle N+1. `transition_request` never rises.
- `cmd_ready` falls the cycle after acceptance and returns the cycle after `rsp_valid`.
- `success` rising in the same cycle the timer expires: success wins (OK/STATE_ERR).
- Reset mid-operation: `transition_request`, `identifier` and `rsp_valid` drop asynchronously. The in-flight command is discarded with no response.

## Structure
- Shared package `lc_pkg`:
  - `LC_WIDTH`, `LC_EOL`.
  - `lc_status_t` (OK/DENIED/REJECTED/STATE_ERR).
  - Requester state enum.
  - The same package serves the responder side.
- One sub-module `lc_req_timer`: loadable up-counter with a terminal-count flag, reused for the REQ timeout and the GUARD count.

## Test plan
- **Grant.** Stimulus: `lc_state`=0, target 1, responder raises `success` 3 cycles after request and moves `lc_state` to 1. Response: OK, `rsp_lc`=1, request held 3 cycles, `identifier`=0 after RELEASE.
- **Deny.** Stimulus: wrong identifier, responder never grants, TIMEOUT=16. Response: request high exactly 16 cycles, DENIED, fail count 1.
- **Pre-check.** Stimulus: `lc_state`=5, target 6; separately `lc_state`=2, target 4. Response: REJECTED at N+1 in both cases, `transition_request` never asserted.
- **Lock.** Stimulus: 3 consecutive DENIED, then a valid command. Response: `locked`=1 and REJECTED. After reset, `locked`=0.
- **Inconsistent grant.** Stimulus: `success`=1 but `lc_state` stays 2 with target 3. Response: STATE_ERR, `rsp_lc`=2.
- **Reset mid-REQ.** Stimulus: assert `rst` low 5 cycles into REQ. Response: all outputs 0 immediately, no `rsp_valid`, `cmd_ready`=1 after reset release.
